// File: rtl/uart_tx_ui.sv
// Debug UART transmitter driven by the superkdf9 user-instruction interface.
// Byte push, status read and flush land in a TX FIFO that an 8N1 serializer drains onto txd.
module uart_tx_ui #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned FIFO_AW  = 4,
  parameter logic [10:0] OP_TX    = 11'h010,
  parameter logic [10:0] OP_STAT  = 11'h011,
  parameter logic [10:0] OP_FLUSH = 11'h012
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] user_opcode,
  input  logic [31:0] user_operand_0,
  input  logic [31:0] user_operand_1,
  input  logic        user_valid,
  output logic        user_complete,
  output logic [31:0] user_result,
  output logic        txd
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = $clog2(BAUD_DIV);
  localparam int unsigned LW    = FIFO_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]      level;
  logic               empty, full;

  state_t             state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [2:0]         bit_idx, bit_idx_d;
  logic [7:0]         shift, shift_d;
  logic               txd_d;

  logic               req, hit_tx, hit_stat, hit_flush;
  logic               push, pop;
  logic [31:0]        stat_word;

  logic               unused_ok;
  assign unused_ok = ^{user_operand_1, user_operand_0[31:8]};

  // The ~user_complete term masks the cycle where the CPU still holds valid after completion.
  assign req       = user_valid & ~user_complete;
  assign hit_tx    = req & (user_opcode == OP_TX);
  assign hit_stat  = req & (user_opcode == OP_STAT);
  assign hit_flush = req & (user_opcode == OP_FLUSH);

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  // A stalled push is accepted on the same edge that a pop frees an entry.
  assign push  = hit_tx & (~full | pop);

  // NOTE: the FIFO storage has no reset; only pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= user_operand_0[7:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (hit_flush) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop)      level <= level + 1'b1;
      else if (pop & ~push) level <= level - 1'b1;
    end
  end

  always_comb begin
    stat_word            = '0;
    stat_word[FIFO_AW:0] = level;
    stat_word[16]        = empty;
    stat_word[17]        = full;
    stat_word[18]        = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      user_complete <= 1'b0;
      user_result   <= '0;
    end else begin
      user_complete <= hit_stat | hit_flush | push;
      user_result   <= hit_stat ? stat_word : '0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (~empty & ~hit_flush) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          cnt_d   = CW'(BAUD_DIV - 1);
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          cnt_d     = CW'(BAUD_DIV - 1);
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_d = CW'(BAUD_DIV - 1);
          if (bit_idx == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
            shift_d   = {1'b0, shift[7:1]};
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (~empty & ~hit_flush) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            cnt_d   = CW'(BAUD_DIV - 1);
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    unique case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      txd     <= txd_d;
    end
  end

endmodule
